// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the two-input gate truth-table sequencer.
package gate_tt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int unsigned VEC_W  = 2;
  localparam int unsigned GATE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Bit positions of each gate result within gate_out
  localparam int unsigned NOT_A = 0;
  localparam int unsigned NOT_B = 1;
  localparam int unsigned AND   = 2;
  localparam int unsigned OR    = 3;
  localparam int unsigned NAND  = 4;
  localparam int unsigned NOR   = 5;
  localparam int unsigned XOR   = 6;
  localparam int unsigned XNOR  = 7;

  // Golden outputs indexed by {a,b}
  localparam logic [GATE_W-1:0] EXP_TT [0:3] = '{8'hB3, 8'h59, 8'h5A, 8'h8C};

endpackage

// File: rtl/gate_tt_golden.sv
// Golden reference: maps the applied {a,b} vector to the expected gate outputs.
module gate_tt_golden
  import gate_tt_pkg::*;
(
  input  logic              a,
  input  logic              b,
  output logic [GATE_W-1:0] expected_c
);

  always_comb expected_c = EXP_TT[{a, b}];

endmodule

// File: rtl/gate_tt_sequencer.sv
// Walks ab = 00..11 into the gate block, checks each output set against the
// golden table and accumulates a mismatch count, sticky bit mask and pass flag.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_out,
  output logic              a,
  output logic              b,
  output logic [VEC_W-1:0]  vec_idx,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [GATE_W-1:0] fail_mask
);

  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                a_d, b_d, busy_d, done_d, pass_d;
  logic [VEC_W-1:0]    vec_d;
  logic [ERR_W-1:0]    err_d, err_chk;
  logic [GATE_W-1:0]   mask_d, diff, expected_c;

  gate_tt_golden u_golden (
    .a          (a),
    .b          (b),
    .expected_c (expected_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_mask <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a         <= a_d;
      b         <= b_d;
      vec_idx   <= vec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      fail_mask <= mask_d;
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a;
    b_d     = b;
    vec_d   = vec_idx;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    err_d   = err_count;
    mask_d  = fail_mask;
    diff    = gate_out ^ expected_c;
    err_chk = err_count;
    if (|diff && (err_count != '1)) err_chk = err_count + ERR_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          mask_d  = '0;
          vec_d   = '0;
        end
      end
      DRIVE: begin
        a_d     = vec_idx[1];
        b_d     = vec_idx[0];
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_LAST)) state_d = CHECK;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      CHECK: begin
        err_d  = err_chk;
        mask_d = fail_mask | diff;
        if (vec_idx != VEC_W'(3)) begin
          vec_d   = vec_idx + VEC_W'(1);
          state_d = DRIVE;
        end else begin
          // pass must include this final vector's result
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_chk == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench: three sequencer configurations driving a behavioural gate block.
module tb_gate_tt_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Default config (SETTLE=2, ERR_W=4) with optional xor stuck-at-0
  logic       start0, a0, b0, busy0, done0, pass0, xor_sa0;
  logic [1:0] vec0;
  logic [3:0] err0;
  logic [7:0] mask0, gout0;
  // ERR_W=2, gate outputs all inverted
  logic       start1, a1, b1, busy1, done1, pass1;
  logic [1:0] vec1, err1;
  logic [7:0] mask1, gout1;
  // SETTLE=0, healthy gate block
  logic       start2, a2, b2, busy2, done2, pass2;
  logic [1:0] vec2;
  logic [3:0] err2;
  logic [7:0] mask2, gout2;

  function automatic logic [7:0] gate_fn(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), x | y, x & y, ~y, ~x};
  endfunction

  always_comb begin
    gout0 = gate_fn(a0, b0);
    if (xor_sa0) gout0[6] = 1'b0;
    gout1 = ~gate_fn(a1, b1);
    gout2 = gate_fn(a2, b2);
  end

  gate_tt_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .gate_out(gout0),
    .a(a0), .b(b0), .vec_idx(vec0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_mask(mask0)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut_e2 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_out(gout1),
    .a(a1), .b(b1), .vec_idx(vec1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(0), .ERR_W(4)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_out(gout2),
    .a(a2), .b(b2), .vec_idx(vec2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_mask(mask2)
  );

  // Pulse start on the default instance and count cycles until done (bounded)
  task automatic run_main(output int n);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL start_flags busy=%b done=%b required busy=1 done=0", busy0, done0);
    end
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a0, b0, vec0, busy0, done0, pass0, err0, mask0} !== 19'd0) begin
      errors++;
      $display("FAIL reset a=%b b=%b vec=%0d busy=%b done=%b pass=%b err=%0d mask=%h required all zero",
               a0, b0, vec0, busy0, done0, pass0, err0, mask0);
    end
  endtask

  task automatic test_clean_run();
    int n;
    run_main(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL clean_latency cycles=%0d required 16", n); end
    checks++;
    if (pass0 !== 1'b1 || err0 !== 4'd0 || mask0 !== 8'h00 || busy0 !== 1'b0) begin
      errors++; $display("FAIL clean_result pass=%b err=%0d mask=%h busy=%b required 1 0 00 0", pass0, err0, mask0, busy0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || {a0, b0} !== 2'b11 || vec0 !== 2'd3) begin
      errors++; $display("FAIL clean_hold done=%b ab=%b%b vec=%0d required 1 11 3", done0, a0, b0, vec0);
    end
  endtask

  task automatic test_xor_stuck();
    int n;
    xor_sa0 = 1'b1;
    run_main(n);
    xor_sa0 = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL xor_latency cycles=%0d required 16", n); end
    checks++;
    if (err0 !== 4'd2 || mask0 !== 8'h40 || pass0 !== 1'b0) begin
      errors++; $display("FAIL xor_result err=%0d mask=%h pass=%b required 2 40 0", err0, mask0, pass0);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk); n++;
      if (n == 9) begin
        checks++;
        if (vec0 !== 2'd2) begin errors++; $display("FAIL mid_vec vec=%0d required 2", vec0); end
        start0 = 1'b1;
      end else begin
        start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL ignore_latency cycles=%0d required 16", n); end
    checks++;
    if (pass0 !== 1'b1 || err0 !== 4'd0 || mask0 !== 8'h00) begin
      errors++; $display("FAIL ignore_result pass=%b err=%0d mask=%h required 1 0 00", pass0, err0, mask0);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    xor_sa0 = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({a0, b0} !== 2'b01 || vec0 !== 2'd1) begin
      errors++; $display("FAIL pre_reset ab=%b%b vec=%0d required 01 1", a0, b0, vec0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, b0, vec0, busy0, done0, pass0, err0, mask0} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset a=%b b=%b vec=%0d busy=%b done=%b pass=%b err=%0d mask=%h required all zero",
               a0, b0, vec0, busy0, done0, pass0, err0, mask0);
    end
    xor_sa0 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_main(n);
    checks++;
    if (n !== 16 || pass0 !== 1'b1 || err0 !== 4'd0 || mask0 !== 8'h00) begin
      errors++; $display("FAIL post_reset_run cycles=%0d pass=%b err=%0d mask=%h required 16 1 0 00", n, pass0, err0, mask0);
    end
  endtask

  task automatic test_saturate();
    int n;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL sat_latency cycles=%0d required 16", n); end
    checks++;
    if (err1 !== 2'd3 || mask1 !== 8'hFF || pass1 !== 1'b0) begin
      errors++; $display("FAIL sat_result err=%0d mask=%h pass=%b required 3 FF 0", err1, mask1, pass1);
    end
  endtask

  task automatic test_no_settle();
    int n;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    n = 0;
    while (!done2 && n < 100) begin
      @(negedge clk); n++;
      if (n == 1 || n == 3 || n == 5 || n == 7) begin
        checks++;
        if ({a2, b2} !== 2'((n - 1) / 2) || busy2 !== 1'b1) begin
          errors++; $display("FAIL s0_vector n=%0d ab=%b%b busy=%b required ab=%0d busy=1", n, a2, b2, busy2, (n - 1) / 2);
        end
      end
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL s0_latency cycles=%0d required 8", n); end
    checks++;
    if (pass2 !== 1'b1 || err2 !== 4'd0 || mask2 !== 8'h00) begin
      errors++; $display("FAIL s0_result pass=%b err=%0d mask=%h required 1 0 00", pass2, err2, mask2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; xor_sa0 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_clean_run();
    test_xor_stuck();
    test_start_ignored();
    test_reset_mid_run();
    test_saturate();
    test_no_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
